// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake states, data word and the
// saturating counter step used by the arbiter watchdog.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [31:0] word_t;

  localparam int WDOG_W = 8;

  function automatic logic [WDOG_W-1:0] wdog_inc(input logic [WDOG_W-1:0] w);
    return (w == {WDOG_W{1'b1}}) ? w : w + {{(WDOG_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data ports.
// Data wins from IDLE; grants alternate under contention; watchdog latches err.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2,
    FAULT  = 2'd3
  } arb_state_t;

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  arb_state_t        state_r;
  logic [WDOG_W-1:0] wdog_r;
  logic              err_r;
  logic              d_req_s;
  logic              access_s;
  logic              ram_err_s;

  assign d_req_s   = dREN | dWEN;
  assign access_s  = (ramstate == ACCESS);
  assign ram_err_s = (ramstate == ERROR);

  assign iload = ramload;
  assign dload = ramload;
  assign err   = err_r;
  assign iwait = iREN    & ~((state_r == IGRANT) & access_s);
  assign dwait = d_req_s & ~((state_r == DGRANT) & access_s);

  // Arbitration FSM with inline watchdog; every state change clears wdog.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
      wdog_r  <= {WDOG_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wdog_r <= {WDOG_W{1'b0}};
          if (d_req_s) begin
            state_r <= DGRANT;
          end else if (iREN) begin
            state_r <= IGRANT;
          end else begin
            state_r <= IDLE;
          end
        end
        DGRANT: begin
          if (ram_err_s) begin
            state_r <= FAULT;
            wdog_r  <= {WDOG_W{1'b0}};
            err_r   <= 1'b1;
          end else if (!d_req_s) begin
            state_r <= IDLE;
            wdog_r  <= {WDOG_W{1'b0}};
          end else if (access_s) begin
            state_r <= iREN ? IGRANT : IDLE;
            wdog_r  <= {WDOG_W{1'b0}};
          end else if (wdog_r == WDOG_LAST) begin
            state_r <= FAULT;
            wdog_r  <= {WDOG_W{1'b0}};
            err_r   <= 1'b1;
          end else begin
            wdog_r  <= wdog_inc(wdog_r);
          end
        end
        IGRANT: begin
          if (ram_err_s) begin
            state_r <= FAULT;
            wdog_r  <= {WDOG_W{1'b0}};
            err_r   <= 1'b1;
          end else if (!iREN) begin
            state_r <= IDLE;
            wdog_r  <= {WDOG_W{1'b0}};
          end else if (access_s) begin
            state_r <= d_req_s ? DGRANT : IDLE;
            wdog_r  <= {WDOG_W{1'b0}};
          end else if (wdog_r == WDOG_LAST) begin
            state_r <= FAULT;
            wdog_r  <= {WDOG_W{1'b0}};
            err_r   <= 1'b1;
          end else begin
            wdog_r  <= wdog_inc(wdog_r);
          end
        end
        FAULT: begin
          err_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          wdog_r  <= {WDOG_W{1'b0}};
        end
      endcase
    end
  end

  // RAM-side mux; IGRANT enable follows iREN so a withdrawn fetch drops at once.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = {ADDR_W{1'b0}};
    ramstore = {DATA_W{1'b0}};
    case (state_r)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
      end
      IGRANT: begin
        ramaddr  = iaddr;
        ramREN   = iREN;
      end
      default: begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus queues expected completions,
// a negedge monitor pops and checks them when iwait/dwait release.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  ramstate_t   ramstate;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] load;
    logic [31:0] addr;
    logic [31:0] store;
    logic        ren;
    logic        wen;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cmp_txn(input string port, input exp_t e, input logic [31:0] load);
    chk({port, "_load"},  load,            e.load);
    chk({port, "_addr"},  ramaddr,         e.addr);
    chk({port, "_store"}, ramstore,        e.store);
    chk({port, "_ren"},   {31'd0, ramREN}, {31'd0, e.ren});
    chk({port, "_wen"},   {31'd0, ramWEN}, {31'd0, e.wen});
  endtask

  // Monitor: a completion is a requester seeing its wait line low.
  always @(negedge CLK) begin
    if (nRST) begin
      if (iREN && !iwait) begin
        if (iq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_i_completion: actual=1 required=0");
        end else begin
          cmp_txn("ifetch", iq.pop_front(), iload);
        end
      end
      if ((dREN || dWEN) && !dwait) begin
        if (dq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_d_completion: actual=1 required=0");
        end else begin
          cmp_txn("data", dq.pop_front(), dload);
        end
      end
    end
  end

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0; ramload = 32'd0;
    ramstate = FREE;
    #2;
    chk("rst_ramREN",   {31'd0, ramREN}, 32'd0);
    chk("rst_ramWEN",   {31'd0, ramWEN}, 32'd0);
    chk("rst_ramaddr",  ramaddr,         32'd0);
    chk("rst_err",      {31'd0, err},    32'd0);
    tick(); tick();
    nRST = 1'b1;

    // 1: reset asserted in the middle of a data write grant
    dWEN = 1'b1; daddr = 32'h0000_0400; dstore = 32'h1234_5678; ramstate = BUSY;
    tick();
    chk("t1_wen_granted", {31'd0, ramWEN}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("t1_wen_async",   {31'd0, ramWEN}, 32'd0);
    chk("t1_addr_async",  ramaddr,         32'd0);
    chk("t1_store_async", ramstore,        32'd0);
    chk("t1_err",         {31'd0, err},    32'd0);
    dWEN = 1'b0; ramstate = FREE;
    tick();
    nRST = 1'b1;
    tick();

    // 2: lone fetch, ACCESS on the second grant cycle
    iREN = 1'b1; iaddr = 32'h0000_0040; ramstate = BUSY;
    iq.push_back('{load: 32'h3C01_0004, addr: 32'h0000_0040, store: 32'd0, ren: 1'b1, wen: 1'b0});
    #1;
    chk("t2_idle_ren",  {31'd0, ramREN}, 32'd0);
    chk("t2_idle_wait", {31'd0, iwait},  32'd1);
    tick();
    chk("t2_g1_ren",  {31'd0, ramREN}, 32'd1);
    chk("t2_g1_addr", ramaddr,         32'h0000_0040);
    chk("t2_g1_wait", {31'd0, iwait},  32'd1);
    tick();
    ramstate = ACCESS; ramload = 32'h3C01_0004;
    #1;
    chk("t2_g2_wait", {31'd0, iwait}, 32'd0);
    tick();
    ramstate = FREE;
    #1;
    chk("t2_back_idle_ren",  {31'd0, ramREN}, 32'd0);
    chk("t2_back_idle_wait", {31'd0, iwait},  32'd1);
    iREN = 1'b0;
    tick();

    // 3: simultaneous fetch and load, data first, no bubble
    iREN = 1'b1; iaddr = 32'h0000_0044; dREN = 1'b1; daddr = 32'h0000_0100;
    dstore = 32'd0; ramstate = BUSY;
    dq.push_back('{load: 32'h1111_2222, addr: 32'h0000_0100, store: 32'd0, ren: 1'b1, wen: 1'b0});
    iq.push_back('{load: 32'h5555_6666, addr: 32'h0000_0044, store: 32'd0, ren: 1'b1, wen: 1'b0});
    tick();
    chk("t3_d_addr",  ramaddr,         32'h0000_0100);
    chk("t3_d_iwait", {31'd0, iwait},  32'd1);
    ramstate = ACCESS; ramload = 32'h1111_2222;
    #1;
    chk("t3_d_dwait", {31'd0, dwait}, 32'd0);
    chk("t3_d_iwait_held", {31'd0, iwait}, 32'd1);
    tick();
    dREN = 1'b0; ramstate = BUSY;
    #1;
    chk("t3_i_addr_nobubble", ramaddr,         32'h0000_0044);
    chk("t3_i_ren",           {31'd0, ramREN}, 32'd1);
    ramstate = ACCESS; ramload = 32'h5555_6666;
    tick();
    iREN = 1'b0; ramstate = FREE;
    tick();

    // 4: read and write together, write wins
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h0000_0200; dstore = 32'hDEAD_BEEF;
    ramstate = BUSY;
    dq.push_back('{load: 32'h0BAD_F00D, addr: 32'h0000_0200, store: 32'hDEAD_BEEF, ren: 1'b0, wen: 1'b1});
    tick();
    chk("t4_dwait_busy", {31'd0, dwait}, 32'd1);
    ramstate = ACCESS; ramload = 32'h0BAD_F00D;
    tick();
    dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    #1;
    chk("t4_idle_wen", {31'd0, ramWEN}, 32'd0);
    tick();

    // 5: fetch withdrawn before ACCESS
    iREN = 1'b1; iaddr = 32'h0000_0080; ramstate = BUSY;
    tick();
    chk("t5_granted_ren", {31'd0, ramREN}, 32'd1);
    iREN = 1'b0;
    #1;
    chk("t5_ren_drop", {31'd0, ramREN}, 32'd0);
    tick();
    iREN = 1'b1;
    #1;
    chk("t5_idle_next", {31'd0, ramREN}, 32'd0);
    iREN = 1'b0;
    tick();

    // 6a: RAM stuck BUSY, watchdog trips after four grant cycles
    dREN = 1'b1; daddr = 32'h0000_0300; ramstate = BUSY;
    tick(); tick(); tick(); tick();
    chk("t6_c4_ren", {31'd0, ramREN}, 32'd1);
    chk("t6_c4_err", {31'd0, err},    32'd0);
    tick();
    chk("t6_fault_err",   {31'd0, err},    32'd1);
    chk("t6_fault_ren",   {31'd0, ramREN}, 32'd0);
    chk("t6_fault_dwait", {31'd0, dwait},  32'd1);
    ramstate = ACCESS;
    #1;
    chk("t6_fault_no_access", {31'd0, dwait}, 32'd1);
    tick(); tick();
    chk("t6_err_sticky", {31'd0, err}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("t6_rst_err", {31'd0, err}, 32'd0);
    dREN = 1'b0; ramstate = FREE;
    tick();
    nRST = 1'b1;
    tick();

    // 6b: ERROR ignored in IDLE, faults on the next edge during a grant
    ramstate = ERROR;
    tick(); tick();
    chk("t6b_idle_error_ignored", {31'd0, err}, 32'd0);
    ramstate = BUSY; dREN = 1'b1; daddr = 32'h0000_0500;
    tick();
    ramstate = ERROR;
    #1;
    chk("t6b_pre_err", {31'd0, err}, 32'd0);
    tick();
    chk("t6b_err",      {31'd0, err},    32'd1);
    chk("t6b_ren_zero", {31'd0, ramREN}, 32'd0);
    dREN = 1'b0; ramstate = FREE;
    tick();

    total++;
    if (iq.size() != 0 || dq.size() != 0) begin
      bad++;
      $display("FAIL pending_completions: actual=%0d required=0", iq.size() + dq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
